// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared single-port data memory.
// Requester 0 is the load/store path, requester 1 the loader/debug port.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              cur_q, cur_d;
  logic              cur_we_q, cur_we_d;
  logic              r0_gnt_d, r1_gnt_d, r0_done_d, r1_done_d;
  logic [DATA_W-1:0] r0_rdata_d, r1_rdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              mem_wen_d, mem_ren_d;

  // Handshake: a requester holds req (with stable we/addr/wdata) until the
  // one-cycle gnt pulse; we/addr/wdata are captured on the grant edge only.
  // The access ends with a one-cycle done pulse, in which req must drop;
  // a requester whose done is high is never eligible, so it cannot re-issue.
  logic              elig0, elig1, sel, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign elig0     = r0_req & ~r0_done;
  assign elig1     = r1_req & ~r1_done;
  // On a tie, the requester not granted last time wins.
  assign sel       = elig1 & (~elig0 | ~last_q);
  assign sel_we    = sel ? r1_we    : r0_we;
  assign sel_addr  = sel ? r1_addr  : r0_addr;
  assign sel_wdata = sel ? r1_wdata : r0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      cur_q     <= 1'b0;
      cur_we_q  <= 1'b0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      cur_we_q  <= cur_we_d;
      r0_gnt    <= r0_gnt_d;
      r1_gnt    <= r1_gnt_d;
      r0_done   <= r0_done_d;
      r1_done   <= r1_done_d;
      r0_rdata  <= r0_rdata_d;
      r1_rdata  <= r1_rdata_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wen   <= mem_wen_d;
      mem_ren   <= mem_ren_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    cur_d       = cur_q;
    cur_we_d    = cur_we_q;
    r0_gnt_d    = 1'b0;
    r1_gnt_d    = 1'b0;
    r0_done_d   = 1'b0;
    r1_done_d   = 1'b0;
    r0_rdata_d  = r0_rdata;
    r1_rdata_d  = r1_rdata;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wen_d   = mem_wen;
    mem_ren_d   = mem_ren;

    if (state_q == IDLE) begin
      if (elig0 | elig1) begin
        state_d    = BUSY;
        last_d     = sel;
        cur_d      = sel;
        cur_we_d   = sel_we;
        r0_gnt_d   = ~sel;
        r1_gnt_d   = sel;
        mem_addr_d = sel_addr;
        if (sel_we) begin
          mem_wdata_d = sel_wdata;
          mem_wen_d   = 1'b1;
          cnt_d       = WR_CNT;
        end else begin
          mem_ren_d   = 1'b1;
          cnt_d       = RD_CNT;
        end
      end
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        // Memory latency has elapsed: mem_rdata is valid at this edge.
        state_d   = IDLE;
        mem_wen_d = 1'b0;
        mem_ren_d = 1'b0;
        r0_done_d = ~cur_q;
        r1_done_d = cur_q;
        if (!cur_we_q) begin
          if (cur_q) r1_rdata_d = mem_rdata;
          else       r0_rdata_d = mem_rdata;
        end
      end
    end
  end

endmodule
